// File: rtl/base_pkg.sv
// Shared helpers for the base_* stream-framing blocks.
package base_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/base_aframe_chan.sv
// One channel of the framing tracker: first flag, saturating beat counter and
// max-length violation detect.
module base_aframe_chan #(
  parameter int beatw  = 8,
  parameter int maxlen = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             end_i,
  input  logic             abort_i,
  output logic             first_o,
  output logic [beatw-1:0] cnt_o,
  output logic             viol_o
);

  localparam bit              HasMax  = (maxlen != 0);
  localparam logic [beatw-1:0] CntMax  = '1;
  localparam logic [beatw-1:0] CntLast = HasMax ? beatw'(maxlen - 1) : '0;

  logic             first_q, first_d;
  logic [beatw-1:0] cnt_q, cnt_d;

  // Abort swallows a coincident beat, so it also suppresses the violation.
  assign viol_o = HasMax & adv_i & ~end_i & ~abort_i & (cnt_q == CntLast);

  always_comb begin
    first_d = first_q;
    cnt_d   = cnt_q;
    if (abort_i || (adv_i && (end_i || viol_o))) begin
      first_d = 1'b1;
      cnt_d   = '0;
    end else if (adv_i) begin
      first_d = 1'b0;
      cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign first_o = first_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/base_aframe_mc.sv
// Multi-channel message-framing tracker: per-channel first/beat-index reporting
// for interleaved valid/ready/end streams, with optional max-length enforcement.
module base_aframe_mc
  import base_pkg::*;
#(
  parameter int ways   = 4,
  parameter int chw    = clog2_min1(ways),
  parameter int beatw  = 8,
  parameter int maxlen = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic             i_r,
  input  logic             i_e,
  input  logic [chw-1:0]   i_ch,
  input  logic [ways-1:0]  i_abort,
  output logic             o_first,
  output logic [beatw-1:0] o_beat,
  output logic [ways-1:0]  o_active,
  output logic             o_err,
  output logic [chw-1:0]   o_err_ch
);

  localparam int unsigned Ways = ways;

  logic             ch_ok;
  logic             acc;
  logic [ways-1:0]  first_w;
  logic [ways-1:0]  viol_w;
  logic [beatw-1:0] cnt_w [ways];

  logic             err_q, err_d;
  logic [chw-1:0]   err_ch_q, err_ch_d;

  assign ch_ok = (32'(i_ch) < Ways);
  assign acc   = i_v & i_r & ch_ok;

  for (genvar g = 0; g < ways; g++) begin : g_chan
    base_aframe_chan #(
      .beatw (beatw),
      .maxlen(maxlen)
    ) u_chan (
      .clk_i  (clk),
      .rst_ni (reset),
      .adv_i  (acc && (i_ch == chw'(g))),
      .end_i  (i_e),
      .abort_i(i_abort[g]),
      .first_o(first_w[g]),
      .cnt_o  (cnt_w[g]),
      .viol_o (viol_w[g])
    );
  end

  // Out-of-range ids fall through to the idle defaults.
  always_comb begin
    o_first = 1'b1;
    o_beat  = '0;
    for (int unsigned k = 0; k < Ways; k++) begin
      if (ch_ok && (32'(i_ch) == k)) begin
        o_first = first_w[k];
        o_beat  = cnt_w[k];
      end
    end
  end

  always_comb begin
    err_d    = |viol_w;
    err_ch_d = '0;
    for (int unsigned k = 0; k < Ways; k++) begin
      if (viol_w[k]) err_ch_d = chw'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q    <= 1'b0;
      err_ch_q <= '0;
    end else begin
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
    end
  end

  assign o_active = ~first_w;
  assign o_err    = err_q;
  assign o_err_ch = err_ch_q;

endmodule

// File: tb/tb_base_aframe_mc.sv
// Bench for base_aframe_mc: four configurations driven from one shared stream,
// directed scenarios plus randomized traffic against a message-length model.
module tb_base_aframe_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v = 1'b0, r = 1'b0, e = 1'b0;
  logic [1:0] ch = '0;
  logic [3:0] ab = '0;

  // inst 0: ways4 bw8 ml0 | 1: ways4 bw8 ml4 | 2: ways3 bw2 ml0 | 3: ways4 bw8 ml1
  logic       f_a, f_b, f_c, f_d;
  logic [7:0] b_a, b_b, b_d;
  logic [1:0] b_c;
  logic [3:0] act_a, act_b, act_d;
  logic [2:0] act_c;
  logic       er_a, er_b, er_c, er_d;
  logic [1:0] ec_a, ec_b, ec_c, ec_d;

  logic       fo  [4];
  logic [7:0] bo  [4];
  logic [3:0] ao  [4];
  logic       eo  [4];
  logic [1:0] eco [4];

  int n_pass = 0;
  int n_total = 0;

  // Model: number of beats accepted so far in each channel's current message.
  int len [4][4];
  bit mexp_err [4];
  int mexp_ech [4];

  always #5 clk = ~clk;

  base_aframe_mc #(.ways(4), .beatw(8), .maxlen(0)) u_a (
    .clk(clk), .reset(rst_n), .i_v(v), .i_r(r), .i_e(e), .i_ch(ch), .i_abort(ab),
    .o_first(f_a), .o_beat(b_a), .o_active(act_a), .o_err(er_a), .o_err_ch(ec_a));
  base_aframe_mc #(.ways(4), .beatw(8), .maxlen(4)) u_b (
    .clk(clk), .reset(rst_n), .i_v(v), .i_r(r), .i_e(e), .i_ch(ch), .i_abort(ab),
    .o_first(f_b), .o_beat(b_b), .o_active(act_b), .o_err(er_b), .o_err_ch(ec_b));
  base_aframe_mc #(.ways(3), .beatw(2), .maxlen(0)) u_c (
    .clk(clk), .reset(rst_n), .i_v(v), .i_r(r), .i_e(e), .i_ch(ch), .i_abort(ab[2:0]),
    .o_first(f_c), .o_beat(b_c), .o_active(act_c), .o_err(er_c), .o_err_ch(ec_c));
  base_aframe_mc #(.ways(4), .beatw(8), .maxlen(1)) u_d (
    .clk(clk), .reset(rst_n), .i_v(v), .i_r(r), .i_e(e), .i_ch(ch), .i_abort(ab),
    .o_first(f_d), .o_beat(b_d), .o_active(act_d), .o_err(er_d), .o_err_ch(ec_d));

  always_comb begin
    fo[0] = f_a; fo[1] = f_b; fo[2] = f_c; fo[3] = f_d;
    bo[0] = b_a; bo[1] = b_b; bo[2] = {6'b0, b_c}; bo[3] = b_d;
    ao[0] = act_a; ao[1] = act_b; ao[2] = {1'b0, act_c}; ao[3] = act_d;
    eo[0] = er_a; eo[1] = er_b; eo[2] = er_c; eo[3] = er_d;
    eco[0] = ec_a; eco[1] = ec_b; eco[2] = ec_c; eco[3] = ec_d;
  end

  function automatic int ml(input int i);
    return (i == 1) ? 4 : (i == 3) ? 1 : 0;
  endfunction
  function automatic int bw(input int i);
    return (i == 2) ? 2 : 8;
  endfunction
  function automatic int wy(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic logic exp_first(input int i);
    if (int'(ch) >= wy(i)) return 1'b1;
    return (len[i][ch] == 0);
  endfunction
  function automatic logic [7:0] exp_beat(input int i);
    int m;
    if (int'(ch) >= wy(i)) return 8'd0;
    m = (1 << bw(i)) - 1;
    return 8'((len[i][ch] > m) ? m : len[i][ch]);
  endfunction
  function automatic logic [3:0] exp_act(input int i);
    logic [3:0] a;
    a = '0;
    for (int k = 0; k < wy(i); k++) a[k] = (len[i][k] != 0);
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      mexp_err[i] = 1'b0;
      for (int k = 0; k < wy(i); k++) begin
        if (ab[k]) len[i][k] = 0;
        else if (v && r && int'(ch) == k) begin
          if (e) len[i][k] = 0;
          else if (ml(i) != 0 && len[i][k] == ml(i) - 1) begin
            len[i][k] = 0;
            mexp_err[i] = 1'b1;
            mexp_ech[i] = k;
          end else len[i][k] = len[i][k] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v = 1'b0; r = 1'b0; e = 1'b0; ch = '0; ab = '0;
    for (int i = 0; i < 4; i++) begin
      mexp_err[i] = 1'b0;
      for (int k = 0; k < 4; k++) len[i][k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    v = 1; r = 1; e = 0; ch = 1;
    tick(); tick();
    #2 rst_n = 1'b0;
    v = 1; r = 0; ch = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (ao[i] !== 4'b0) $display("FAIL reset_active inst%0d got %b want 0000", i, ao[i]); else n_pass++;
      n_total++; if (eo[i] !== 1'b0) $display("FAIL reset_err inst%0d got %b want 0", i, eo[i]); else n_pass++;
      n_total++; if (eco[i] !== 2'd0) $display("FAIL reset_err_ch inst%0d got %0d want 0", i, eco[i]); else n_pass++;
      n_total++; if (fo[i] !== 1'b1 || bo[i] !== 8'd0)
        $display("FAIL reset_first inst%0d got first=%b beat=%0d want 1/0", i, fo[i], bo[i]); else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_single();
    logic       xf [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] xb [3] = '{8'd0, 8'd1, 8'd2};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      v = 1; r = 1; e = (n == 2); ch = 0;
      #1;
      n_total++; if (fo[0] !== xf[n] || bo[0] !== xb[n])
        $display("FAIL single_beat%0d got first=%b beat=%0d want %b/%0d", n, fo[0], bo[0], xf[n], xb[n]); else n_pass++;
      tick();
    end
    r = 0; e = 0;
    #1;
    n_total++; if (fo[0] !== 1'b1 || bo[0] !== 8'd0)
      $display("FAIL single_next got first=%b beat=%0d want 1/0", fo[0], bo[0]); else n_pass++;
  endtask

  task automatic test_interleave();
    logic [1:0] sc [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    logic       se [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] xb [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      v = 1; r = 1; e = se[n]; ch = sc[n];
      #1;
      n_total++; if (bo[0] !== xb[n])
        $display("FAIL interleave_beat%0d ch%0d got %0d want %0d", n, sc[n], bo[0], xb[n]); else n_pass++;
      tick();
    end
    v = 0;
    n_total++; if (ao[0] !== 4'b0001) $display("FAIL interleave_active got %b want 0001", ao[0]); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    v = 1; r = 0; e = 0; ch = 1;
    for (int n = 0; n < 5; n++) begin
      #1;
      n_total++; if (fo[0] !== 1'b1 || bo[0] !== 8'd0)
        $display("FAIL bp_first cyc%0d got first=%b beat=%0d want 1/0", n, fo[0], bo[0]); else n_pass++;
      tick();
      n_total++; if (ao[0] !== 4'b0) $display("FAIL bp_active cyc%0d got %b want 0000", n, ao[0]); else n_pass++;
    end
    v = 0;
  endtask

  task automatic test_maxlen();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      v = 1; r = 1; e = 0; ch = 3;
      #1;
      n_total++; if (fo[1] !== (n == 0 || n == 4) || bo[1] !== ((n == 4) ? 8'd0 : 8'(n)))
        $display("FAIL maxlen_beat%0d got first=%b beat=%0d", n, fo[1], bo[1]); else n_pass++;
      n_total++; if (fo[3] !== 1'b1 || bo[3] !== 8'd0)
        $display("FAIL ml1_first beat%0d got first=%b beat=%0d want 1/0", n, fo[3], bo[3]); else n_pass++;
      tick();
      n_total++; if (eo[1] !== (n == 3)) $display("FAIL maxlen_err beat%0d got %b want %b", n, eo[1], n == 3); else n_pass++;
      if (n == 3) begin
        n_total++; if (eco[1] !== 2'd3) $display("FAIL maxlen_err_ch got %0d want 3", eco[1]); else n_pass++;
      end
      n_total++; if (eo[3] !== 1'b1 || eco[3] !== 2'd3)
        $display("FAIL ml1_err beat%0d got err=%b ch=%0d want 1/3", n, eo[3], eco[3]); else n_pass++;
    end
    v = 0;
    tick();
    n_total++; if (eo[1] !== 1'b0 || eo[3] !== 1'b0)
      $display("FAIL err_pulse_end got %b/%b want 0/0", eo[1], eo[3]); else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    v = 1; r = 1; e = 0; ch = 1;
    tick(); tick();
    ab = 4'b0010;
    #1;
    n_total++; if (bo[0] !== 8'd2) $display("FAIL abort_precnt got %0d want 2", bo[0]); else n_pass++;
    tick();
    ab = '0; r = 0;
    #1;
    n_total++; if (ao[0][1] !== 1'b0) $display("FAIL abort_active got %b want 0", ao[0][1]); else n_pass++;
    n_total++; if (fo[0] !== 1'b1 || bo[0] !== 8'd0)
      $display("FAIL abort_beat got first=%b beat=%0d want 1/0", fo[0], bo[0]); else n_pass++;
    n_total++; if (eo[3] !== 1'b0 || eo[1] !== 1'b0)
      $display("FAIL abort_noerr got %b/%b want 0/0", eo[3], eo[1]); else n_pass++;
    v = 0;
  endtask

  task automatic test_saturate();
    logic [7:0] xb [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    do_reset();
    for (int n = 0; n < 6; n++) begin
      v = 1; r = 1; e = (n == 5); ch = 1;
      #1;
      n_total++; if (bo[2] !== xb[n]) $display("FAIL sat_beat%0d got %0d want %0d", n, bo[2], xb[n]); else n_pass++;
      tick();
      n_total++; if (eo[2] !== 1'b0) $display("FAIL sat_err beat%0d got %b want 0", n, eo[2]); else n_pass++;
    end
    v = 1; r = 1; e = 0; ch = 3;
    #1;
    n_total++; if (fo[2] !== 1'b1 || bo[2] !== 8'd0)
      $display("FAIL oob_ch got first=%b beat=%0d want 1/0", fo[2], bo[2]); else n_pass++;
    tick();
    n_total++; if (ao[2] !== 4'b0 || eo[2] !== 1'b0)
      $display("FAIL oob_nochange got act=%b err=%b want 0000/0", ao[2], eo[2]); else n_pass++;
    v = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom % 4) != 0;
      r  = ($urandom % 3) != 0;
      e  = ($urandom % 6) == 0;
      ch = 2'($urandom);
      ab = (($urandom % 12) == 0) ? 4'($urandom) : 4'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
        n_total++; if (fo[i] !== exp_first(i) || bo[i] !== exp_beat(i))
          $display("FAIL rnd_out cyc%0d inst%0d got first=%b beat=%0d want %b/%0d",
                   n, i, fo[i], bo[i], exp_first(i), exp_beat(i)); else n_pass++;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        n_total++; if (ao[i] !== exp_act(i))
          $display("FAIL rnd_active cyc%0d inst%0d got %b want %b", n, i, ao[i], exp_act(i)); else n_pass++;
        n_total++; if (eo[i] !== mexp_err[i])
          $display("FAIL rnd_err cyc%0d inst%0d got %b want %b", n, i, eo[i], mexp_err[i]); else n_pass++;
        if (mexp_err[i]) begin
          n_total++; if (int'(eco[i]) != mexp_ech[i])
            $display("FAIL rnd_err_ch cyc%0d inst%0d got %0d want %0d", n, i, eco[i], mexp_ech[i]); else n_pass++;
        end
      end
    end
    v = 0; ab = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_backpressure();
    test_maxlen();
    test_abort();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
